// File: rtl/dfe_pkg.sv
// Shared types and helpers for the notch-filter chain output sink.
// Stage bit indices match the order of the per-stage saturation flag vectors.
package dfe_pkg;

    localparam int DFE_DATA_W = 16;

    localparam int STG_2_4MHZ = 0;
    localparam int STG_1MHZ   = 1;

    // Layout of one FIFO entry at the default sample width; the sink uses {sat, data}.
    typedef struct packed {
        logic                  sat;
        logic [DFE_DATA_W-1:0] data;
    } sink_entry_t;

    // One extra pointer bit distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dfe_sync_fifo.sv
// Generic single-clock FIFO, first-word fall-through read, read data masked to 0 when empty.
// Latency: write visible on rd_data the cycle after push; no internal backpressure (caller gates push).
module dfe_sync_fifo
    import dfe_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8,
    localparam int PW   = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [PW-1:0]    level
);

    localparam int AW = PW - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage has no reset; the read port is masked while empty instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/dfe_stream_sink.sv
// Captures filter-chain samples plus saturation flags into a FIFO and presents them on ready/valid.
// Latency 1 cycle to m_valid; upstream cannot stall, so samples arriving on a full FIFO are dropped.
// Statistics (drop/sat counters, sticky flags) exist only when DFE_SINK_STATS_EN is defined.
module dfe_stream_sink
    import dfe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16,
    localparam int LW        = ptr_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            ovf_in,
    input  logic [1:0]            udf_in,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sat,
    output logic [LW-1:0]         fifo_level,
    output logic                  drop_pulse,
    input  logic                  clr_stats,
    output logic [CNT_WIDTH-1:0]  drop_count,
    output logic [CNT_WIDTH-1:0]  sat_count,
    output logic [1:0]            sticky_ovf,
    output logic [1:0]            sticky_udf
);

    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                drop;
    logic                sat;
    logic [DATA_WIDTH:0] wr_entry;
    logic [DATA_WIDTH:0] rd_entry;

    assign sat  = ovf_in[STG_2_4MHZ] | ovf_in[STG_1MHZ] | udf_in[STG_2_4MHZ] | udf_in[STG_1MHZ];
    assign pop  = !empty && m_ready;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign push = valid_in && (!full || pop);
    assign drop = valid_in && full && !pop;

    assign wr_entry = {sat, data_in};

    dfe_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    assign m_valid = !empty;
    assign m_sat   = rd_entry[DATA_WIDTH];
    assign m_data  = rd_entry[DATA_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= drop;
        end
    end

`ifdef DFE_SINK_STATS_EN
    // Clear takes priority; counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
            sat_count  <= '0;
            sticky_ovf <= '0;
            sticky_udf <= '0;
        end else if (clr_stats) begin
            drop_count <= '0;
            sat_count  <= '0;
            sticky_ovf <= '0;
            sticky_udf <= '0;
        end else begin
            if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
            if (push && sat && (sat_count != '1)) sat_count <= sat_count + 1'b1;
            if (valid_in) begin
                sticky_ovf <= sticky_ovf | ovf_in;
                sticky_udf <= sticky_udf | udf_in;
            end
        end
    end
`else
    logic unused_clr_stats;
    assign unused_clr_stats = clr_stats;
    assign drop_count = '0;
    assign sat_count  = '0;
    assign sticky_ovf = '0;
    assign sticky_udf = '0;
`endif

endmodule

// File: tb/tb_dfe_stream_sink.sv
// Directed self-checking bench for dfe_stream_sink; stats expectations follow DFE_SINK_STATS_EN.
module tb_dfe_stream_sink;

`ifdef DFE_SINK_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [15:0] data_in;
    logic [1:0]  ovf_in;
    logic [1:0]  udf_in;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_sat;
    logic [3:0]  fifo_level;
    logic        drop_pulse;
    logic        clr_stats;
    logic [15:0] drop_count;
    logic [15:0] sat_count;
    logic [1:0]  sticky_ovf;
    logic [1:0]  sticky_udf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dfe_stream_sink dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .ovf_in     (ovf_in),
        .udf_in     (udf_in),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_sat      (m_sat),
        .fifo_level (fifo_level),
        .drop_pulse (drop_pulse),
        .clr_stats  (clr_stats),
        .drop_count (drop_count),
        .sat_count  (sat_count),
        .sticky_ovf (sticky_ovf),
        .sticky_udf (sticky_udf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b0; data_in = '0; ovf_in = '0; udf_in = '0;
        m_ready = 1'b0; clr_stats = 1'b0;
        step(); step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        checks++; if (m_data !== 16'h0) begin errors++; $display("FAIL reset_m_data: got %h want 0000", m_data); end
        checks++; if (m_sat !== 1'b0) begin errors++; $display("FAIL reset_m_sat: got %b want 0", m_sat); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL reset_drop_pulse: got %b want 0", drop_pulse); end
        checks++; if ({drop_count, sat_count, sticky_ovf, sticky_udf} !== 36'h0) begin
            errors++; $display("FAIL reset_stats: got %h want 0", {drop_count, sat_count, sticky_ovf, sticky_udf}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        m_ready = 1'b1;
        valid_in = 1'b1; data_in = 16'h1234;
        step();
        valid_in = 1'b0;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", m_valid); end
        checks++; if (m_data !== 16'h1234) begin errors++; $display("FAIL single_data: got %h want 1234", m_data); end
        checks++; if (m_sat !== 1'b0) begin errors++; $display("FAIL single_sat: got %b want 0", m_sat); end
        step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b want 0", m_valid); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL single_level: got %0d want 0", fifo_level); end
        m_ready = 1'b0;
    endtask

    task automatic test_fill_drop();
        int drops = 0;
        m_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            valid_in = 1'b1; data_in = 16'(i);
            step();
            if (drop_pulse === 1'b1) drops++;
            if (i == 9) begin
                checks++; if (m_data !== 16'd1) begin errors++; $display("FAIL stall_hold: got %h want 0001", m_data); end
            end
        end
        valid_in = 1'b0;
        checks++; if (drops != 2) begin errors++; $display("FAIL drop_pulses: got %0d want 2", drops); end
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL fill_level: got %0d want 8", fifo_level); end
        checks++; if (drop_count !== 16'(2 * STATS)) begin errors++; $display("FAIL drop_count: got %0d want %0d", drop_count, 2 * STATS); end
        step();
        checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL drop_pulse_width: got %b want 0", drop_pulse); end
        m_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            checks++; if (m_valid !== 1'b1 || m_data !== 16'(k)) begin
                errors++; $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", k, m_valid, m_data, 16'(k)); end
            step();
        end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", m_valid); end
        m_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'b1; data_in = 16'h0100 + 16'(i);
            step();
        end
        data_in = 16'h0200; m_ready = 1'b1;
        step();
        valid_in = 1'b0; m_ready = 1'b0;
        checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL b2b_no_drop: got %b want 0", drop_pulse); end
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL b2b_level: got %0d want 8", fifo_level); end
        checks++; if (drop_count !== 16'(2 * STATS)) begin errors++; $display("FAIL b2b_drop_count: got %0d want %0d", drop_count, 2 * STATS); end
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp = (k < 7) ? 16'h0101 + 16'(k) : 16'h0200;
            checks++; if (m_valid !== 1'b1 || m_data !== exp) begin
                errors++; $display("FAIL b2b_drain_%0d: got v=%b d=%h want v=1 d=%h", k, m_valid, m_data, exp); end
            step();
        end
        m_ready = 1'b0;
    endtask

    task automatic test_flags();
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL clr_drop_count: got %0d want 0", drop_count); end
        valid_in = 1'b1; data_in = 16'h0055; ovf_in = 2'b10;
        step();
        valid_in = 1'b0; ovf_in = 2'b00;
        checks++; if (m_valid !== 1'b1 || m_sat !== 1'b1 || m_data !== 16'h0055) begin
            errors++; $display("FAIL flag_sample: got v=%b s=%b d=%h want v=1 s=1 d=0055", m_valid, m_sat, m_data); end
        checks++; if (sat_count !== 16'(STATS)) begin errors++; $display("FAIL sat_count: got %0d want %0d", sat_count, STATS); end
        checks++; if (sticky_ovf !== 2'(2 * STATS)) begin errors++; $display("FAIL sticky_ovf: got %b want %b", sticky_ovf, 2'(2 * STATS)); end
        valid_in = 1'b1; data_in = 16'h0066; udf_in = 2'b01; clr_stats = 1'b1;
        step();
        valid_in = 1'b0; udf_in = 2'b00; clr_stats = 1'b0;
        checks++; if ({sat_count, sticky_ovf, sticky_udf} !== 20'h0) begin
            errors++; $display("FAIL clr_wins: got %h want 0", {sat_count, sticky_ovf, sticky_udf}); end
        checks++; if (fifo_level !== 4'd2) begin errors++; $display("FAIL clr_keeps_fifo: got %0d want 2", fifo_level); end
        for (int i = 0; i < 6; i++) begin
            valid_in = 1'b1; data_in = 16'h0070 + 16'(i);
            step();
        end
        data_in = 16'h0BAD; ovf_in = 2'b01;
        step();
        valid_in = 1'b0; ovf_in = 2'b00;
        checks++; if (drop_pulse !== 1'b1) begin errors++; $display("FAIL flag_drop_pulse: got %b want 1", drop_pulse); end
        checks++; if (drop_count !== 16'(STATS)) begin errors++; $display("FAIL flag_drop_count: got %0d want %0d", drop_count, STATS); end
        checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL dropped_not_sat: got %0d want 0", sat_count); end
        ovf_in = 2'b11; udf_in = 2'b11;
        step();
        ovf_in = 2'b00; udf_in = 2'b00;
        checks++; if (sticky_ovf !== 2'(STATS) || sticky_udf !== 2'b00) begin
            errors++; $display("FAIL sticky_on_drop: got o=%b u=%b want o=%b u=00", sticky_ovf, sticky_udf, 2'(STATS)); end
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (m_sat !== (k < 2)) begin errors++; $display("FAIL sat_drain_%0d: got %b want %b", k, m_sat, (k < 2)); end
            step();
        end
        m_ready = 1'b0;
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL flag_drain_level: got %0d want 0", fifo_level); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            valid_in = 1'b1; data_in = 16'h0010 + 16'(i);
            step();
        end
        valid_in = 1'b0;
        checks++; if (fifo_level !== 4'd5) begin errors++; $display("FAIL mid_level_pre: got %0d want 5", fifo_level); end
        #2 rst = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0 || fifo_level !== 4'd0 || m_data !== 16'h0) begin
            errors++; $display("FAIL mid_reset_async: got v=%b l=%0d d=%h want v=0 l=0 d=0000", m_valid, fifo_level, m_data); end
        step();
        rst = 1'b0;
        valid_in = 1'b1; data_in = 16'h7FFF;
        step();
        valid_in = 1'b0;
        checks++; if (m_valid !== 1'b1 || m_data !== 16'h7FFF || fifo_level !== 4'd1) begin
            errors++; $display("FAIL post_reset_sample: got v=%b d=%h l=%0d want v=1 d=7fff l=1", m_valid, m_data, fifo_level); end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL post_reset_drain: got %b want 0", m_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drop();
        test_back_to_back();
        test_flags();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
